// File: rtl/fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// uarch_pkg / fetch_buffer_if
//
// uarch_pkg holds the machine-wide widths shared by the front end.
//
// fetch_buffer_if bundles the two valid/ready channels around the fetch
// buffer:
//   fetch side : fetch_pc, fetch_inst0, fetch_inst1, fetch_val -> buffer
//                fetch_rdy                                     <- buffer
//   decode side: dec_pc, dec_pc_4, dec_inst0, dec_inst1,
//                dec_val                                       <- buffer
//                dec_rdy                                       -> buffer
// modport master : the environment (fetch unit + decoder) around the buffer
// modport slave  : the fetch buffer itself
// ---------------------------------------------------------------------------
package uarch_pkg;
  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_INST_BITS = 32;
endpackage

interface fetch_buffer_if #(
  parameter int ADDR_W = uarch_pkg::CPU_ADDR_BITS,
  parameter int INST_W = uarch_pkg::CPU_INST_BITS
);
  logic [ADDR_W-1:0] fetch_pc;
  logic [INST_W-1:0] fetch_inst0;
  logic [INST_W-1:0] fetch_inst1;
  logic              fetch_val;
  logic              fetch_rdy;

  logic [ADDR_W-1:0] dec_pc;
  logic [ADDR_W-1:0] dec_pc_4;
  logic [INST_W-1:0] dec_inst0;
  logic [INST_W-1:0] dec_inst1;
  logic              dec_val;
  logic              dec_rdy;

  modport master (
    output fetch_pc, fetch_inst0, fetch_inst1, fetch_val, dec_rdy,
    input  fetch_rdy, dec_pc, dec_pc_4, dec_inst0, dec_inst1, dec_val
  );

  modport slave (
    input  fetch_pc, fetch_inst0, fetch_inst1, fetch_val, dec_rdy,
    output fetch_rdy, dec_pc, dec_pc_4, dec_inst0, dec_inst1, dec_val
  );
endinterface

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//
// Decoupling FIFO between fetch and decode. Each entry is one fetch packet
// (pc, inst0 at pc, inst1 at pc+4). It soaks up decoder back-pressure so the
// fetch unit can keep issuing I-cache reads; fetch_rdy feeds fetch's
// decoder_rdy. A flush (pipeline redirect) discards every stored packet.
//
// Parameters
//   DEPTH          packet entries, power of two, >= 2
//   CPU_ADDR_BITS  pc width          (uarch_pkg)
//   CPU_INST_BITS  instruction width (uarch_pkg)
//
// Ports
//   clk    clock, all state changes on posedge
//   rst    synchronous active-high reset, dominates flush and traffic
//   flush  drop all packets; no push/pop while asserted
//   bus    fetch_buffer_if.slave (fetch and decode handshakes)
//   count  occupied entries, 0..DEPTH
//
// Build option
//   FETCH_BUFFER_BYPASS_EN  when defined, a packet arriving at an empty
//                           buffer is presented on dec_* in the same cycle
//                           and is only written if the decoder stalls.
//                           Undefined: dec_* are pure register outputs with
//                           one cycle of fetch->decode latency.
// ---------------------------------------------------------------------------
module fetch_buffer #(
  parameter int DEPTH         = 4,
  parameter int CPU_ADDR_BITS = uarch_pkg::CPU_ADDR_BITS,
  parameter int CPU_INST_BITS = uarch_pkg::CPU_INST_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fetch_buffer_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [CPU_INST_BITS-1:0] inst0;
    logic [CPU_INST_BITS-1:0] inst1;
  } pkt_t;

  pkt_t             mem [DEPTH];
  pkt_t             in_pkt;
  pkt_t             head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             push;   // fetch handshake completes this cycle
  logic             pop;    // decode handshake completes this cycle
  logic             wr_en;  // packet actually lands in storage
  logic             rd_en;  // stored head actually leaves storage

  assign in_pkt = '{pc: bus.fetch_pc, inst0: bus.fetch_inst0, inst1: bus.fetch_inst1};

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Readiness looks only at occupancy and flush, never at dec_rdy, so no
  // combinational path runs from the decoder back into the fetch unit. A
  // full buffer that pops this cycle therefore opens up only next cycle.
  assign bus.fetch_rdy = ~full & ~flush;
  assign push          = bus.fetch_val & bus.fetch_rdy;

`ifdef FETCH_BUFFER_BYPASS_EN
  logic bypass;

  // Empty buffer with a live packet: show it to decode straight away.
  assign bypass      = empty & bus.fetch_val & ~flush;
  assign head        = bypass ? in_pkt : mem[rd_ptr];
  assign bus.dec_val = (~empty & ~flush) | bypass;
  assign pop         = bus.dec_val & bus.dec_rdy;
  // A bypassed packet taken by decode the same cycle never touches storage.
  assign wr_en       = push & ~(bypass & bus.dec_rdy);
  assign rd_en       = pop & ~bypass;
`else
  assign head        = mem[rd_ptr];
  assign bus.dec_val = ~empty & ~flush;
  assign pop         = bus.dec_val & bus.dec_rdy;
  assign wr_en       = push;
  assign rd_en       = pop;
`endif

  assign bus.dec_pc    = head.pc;
  // Wraps modulo 2^CPU_ADDR_BITS by construction of the sized add.
  assign bus.dec_pc_4  = head.pc + CPU_ADDR_BITS'(4);
  assign bus.dec_inst0 = head.inst0;
  assign bus.dec_inst1 = head.inst1;

  // Pointers and occupancy. Reset and flush are both synchronous and have
  // the same effect; flush already blocks push/pop through the handshakes,
  // so clearing here cannot lose an accepted packet.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps DEPTH-1 -> 0.
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;  // idle, or push+pop balanced
      endcase
    end
  end

  // Packet storage.
  // NOTE: the data array is deliberately left out of reset; dec_val gates
  // its contents, and a reset would turn cheap RAM into a wide flop bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_pkt;
  end

  // Structural invariants.
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count <= FULL_CNT);
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    full |-> !wr_en);
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    empty |-> !rd_en);
  a_flush_quiet : assert property (@(posedge clk) disable iff (rst)
    flush |-> !(push || pop));

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//
// Scoreboard bench for fetch_buffer. A negedge monitor pushes every accepted
// fetch packet into a queue and compares the head against dec_* whenever
// dec_val is high, popping on dec_rdy. It also predicts count, fetch_rdy and
// dec_val from the queue occupancy. Directed sequences cover reset, streaming,
// fill/back-pressure, simultaneous push+pop with pointer wrap, flush, and pc
// wrap at the top of the address space (same-cycle under the bypass build).
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [$clog2(DEPTH):0] count;

  fetch_buffer_if bus ();

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor / scoreboard: sampled on negedge, between driving edges.
  always @(negedge clk) begin
    logic exp_val;
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      check("count", 32'(count), 32'(sb_q.size()));
      check("fetch_rdy", 32'(bus.fetch_rdy), 32'((sb_q.size() != DEPTH) && !flush));
`ifdef FETCH_BUFFER_BYPASS_EN
      exp_val = ((sb_q.size() != 0) || bus.fetch_val) && !flush;
`else
      exp_val = (sb_q.size() != 0) && !flush;
`endif
      check("dec_val", 32'(bus.dec_val), 32'(exp_val));
      if (bus.fetch_val && bus.fetch_rdy)
        sb_q.push_back('{pc: bus.fetch_pc, i0: bus.fetch_inst0, i1: bus.fetch_inst1});
      if (bus.dec_val) begin
        if (sb_q.size() == 0) begin
          check("sb_underrun", 32'(1), 32'(0));
        end else begin
          e = sb_q[0];
          check("sb_pc",    bus.dec_pc,    e.pc);
          check("sb_pc_4",  bus.dec_pc_4,  e.pc + 32'd4);
          check("sb_inst0", bus.dec_inst0, e.i0);
          check("sb_inst1", bus.dec_inst1, e.i1);
          if (bus.dec_rdy) void'(sb_q.pop_front());
        end
      end
      if (flush) sb_q.delete();
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one packet and hold it until accepted. Call just after posedge;
  // returns just after the accepting edge with fetch_val low.
  task automatic send(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
    bit ok = 1'b0;
    bus.fetch_pc    = pc;
    bus.fetch_inst0 = i0;
    bus.fetch_inst1 = i1;
    bus.fetch_val   = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.fetch_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    bus.fetch_val = 1'b0;
    if (!ok) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_rand(input logic [31:0] pc);
    send(pc, $urandom(), $urandom());
  endtask

  // Wait for the buffer and scoreboard to empty, bounded.
  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && count == '0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    if (!ok) check("drain_timeout", 32'(0), 32'(1));
  endtask

  // Packet near the top of the address space with decode ready.
  task automatic wrap_case(input logic [31:0] pc, input logic [31:0] exp_pc4);
    bus.fetch_pc    = pc;
    bus.fetch_inst0 = $urandom();
    bus.fetch_inst1 = $urandom();
    bus.fetch_val   = 1'b1;
    @(negedge clk);
`ifdef FETCH_BUFFER_BYPASS_EN
    check("byp_val",   32'(bus.dec_val), 32'(1));
    check("byp_pc",    bus.dec_pc,       pc);
    check("byp_pc_4",  bus.dec_pc_4,     exp_pc4);
    check("byp_count", 32'(count),       32'(0));
    tick();
    bus.fetch_val = 1'b0;
    check("byp_count_after", 32'(count), 32'(0));
`else
    tick();
    bus.fetch_val = 1'b0;
    @(negedge clk);
    check("wrap_val",  32'(bus.dec_val), 32'(1));
    check("wrap_pc",   bus.dec_pc,       pc);
    check("wrap_pc_4", bus.dec_pc_4,     exp_pc4);
    tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    bus.fetch_val   = 1'b0;
    bus.fetch_pc    = '0;
    bus.fetch_inst0 = '0;
    bus.fetch_inst1 = '0;
    bus.dec_rdy     = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_count",     32'(count),         32'(0));
    check("rst_dec_val",   32'(bus.dec_val),   32'(0));
    check("rst_fetch_rdy", 32'(bus.fetch_rdy), 32'(1));
    tick();

    // Streaming with decoder always ready
    bus.dec_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_rand(32'(i * 8));
      check("stream_count_le1", 32'(count <= 1), 32'(1));
    end
    drain();

    // Fill and back-pressure
    bus.dec_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(32'(i * 8));
    @(negedge clk);
    check("full_count", 32'(count),         32'(DEPTH));
    check("full_rdy",   32'(bus.fetch_rdy), 32'(0));
    tick();
    bus.fetch_pc    = 32'h20;
    bus.fetch_inst0 = 32'h1234_5678;
    bus.fetch_inst1 = 32'h9ABC_DEF0;
    bus.fetch_val   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("held_rdy",   32'(bus.fetch_rdy), 32'(0));
      check("held_count", 32'(count),         32'(DEPTH));
    end
    tick();
    bus.dec_rdy = 1'b1;
    send(32'h20, 32'h1234_5678, 32'h9ABC_DEF0);
    drain();

    // Simultaneous push+pop at count=2, pointers wrap
    bus.dec_rdy = 1'b0;
    send_rand(32'h100);
    send_rand(32'h108);
    check("pp_start_count", 32'(count), 32'(2));
    bus.dec_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_rand(32'h110 + 32'(i * 8));
      check("pp_count", 32'(count), 32'(2));
    end
    drain();

    // Flush with a packet presented in the same cycle
    bus.dec_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(32'h200 + 32'(i * 8));
    check("pre_flush_count", 32'(count), 32'(3));
    flush           = 1'b1;
    bus.fetch_pc    = 32'hA000;
    bus.fetch_inst0 = 32'h1111_1111;
    bus.fetch_inst1 = 32'h2222_2222;
    bus.fetch_val   = 1'b1;
    @(negedge clk);
    check("flush_dec_val", 32'(bus.dec_val),   32'(0));
    check("flush_rdy",     32'(bus.fetch_rdy), 32'(0));
    tick();
    flush         = 1'b0;
    bus.fetch_val = 1'b0;
    check("post_flush_count", 32'(count), 32'(0));
    send(32'hA000, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    @(negedge clk);
    check("refill_val",   32'(bus.dec_val), 32'(1));
    check("refill_pc",    bus.dec_pc,       32'hA000);
    check("refill_inst0", bus.dec_inst0,    32'hAAAA_AAAA);
    check("refill_inst1", bus.dec_inst1,    32'hBBBB_BBBB);
    check("refill_count", 32'(count),       32'(1));
    tick();
    bus.dec_rdy = 1'b1;
    drain();

    // Flush on an empty buffer
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("empty_flush_count", 32'(count), 32'(0));

    // pc wrap at the top of the address space
    bus.dec_rdy = 1'b1;
    wrap_case(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    wrap_case(32'hFFFF_FFFC, 32'h0000_0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
